// File: rtl/des_pkg.sv
// Shared DES key-schedule constants: PC-1/PC-2 tables (FIPS 1-based), shift schedule
// and the permutation helpers used by the scheduler and its round slice.
package des_pkg;

  localparam int SUBKEY_W = 48;
  localparam int ROUNDS   = 16;
  localparam int KEYEX_W  = SUBKEY_W * ROUNDS;

  localparam int unsigned PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,
     1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27,
    19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,
     7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29,
    21, 13,  5, 28, 20, 12,  4
  };

  localparam int unsigned PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Left-rotate amount for rounds 1..16 (index 0 = round 1).
  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // FIPS bit b of a W-bit vector lives at vector index W-b.
  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[55-i] = k[64-PC1_TBL[i]];
    end
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[47-i] = cd[56-PC2_TBL[i]];
    end
    return r;
  endfunction

endpackage

// File: rtl/des_key_round.sv
// One key-schedule round: rotate C and D halves left by 1 or 2, then PC-2 into a subkey.
module des_key_round
  import des_pkg::*;
(
  input  logic [27:0]         i_c,
  input  logic [27:0]         i_d,
  input  logic [1:0]          i_shift,
  output logic [27:0]         o_c,
  output logic [27:0]         o_d,
  output logic [SUBKEY_W-1:0] o_subkey
);

  logic [27:0] w_c;
  logic [27:0] w_d;

  always_comb begin
    if (i_shift == 2'd2) begin
      w_c = {i_c[25:0], i_c[27:26]};
      w_d = {i_d[25:0], i_d[27:26]};
    end else begin
      w_c = {i_c[26:0], i_c[27]};
      w_d = {i_d[26:0], i_d[27]};
    end
  end

  assign o_c      = w_c;
  assign o_d      = w_d;
  assign o_subkey = pc2({w_c, w_d});

endmodule

// File: rtl/des_key_sched.sv
// Sequential DES key schedule: PC-1 on load, then one subkey per clock into a
// 768-bit store (K1 in the top slice, K16 in the bottom).
module des_key_sched
  import des_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [63:0]        i_key,
  input  logic               i_key_en,
  output logic [KEYEX_W-1:0] o_keyex,
  output logic               o_key_vld,
  output logic               o_key_done,
  output logic               o_busy
);

  logic [27:0]         r_c;
  logic [27:0]         r_d;
  logic [4:0]          r_round;
  logic [KEYEX_W-1:0]  r_keyex;
  logic                r_vld;
  logic                r_done;
  logic                r_busy;

  logic [3:0]          w_rnd_idx;
  logic [1:0]          w_shift;
  logic [27:0]         w_c;
  logic [27:0]         w_d;
  logic [SUBKEY_W-1:0] w_subkey;

  // Rounds 1..16 map to table entries 0..15; the 4-bit wrap takes 16 to 15.
  assign w_rnd_idx = r_round[3:0] - 4'd1;
  assign w_shift   = SHIFT_TBL[w_rnd_idx];

  des_key_round u_round (
    .i_c      (r_c),
    .i_d      (r_d),
    .i_shift  (w_shift),
    .o_c      (w_c),
    .o_d      (w_d),
    .o_subkey (w_subkey)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_c     <= '0;
      r_d     <= '0;
      r_round <= '0;
      r_keyex <= '0;
      r_vld   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else if (i_key_en) begin
      // A strobe always restarts, even mid-schedule; the store keeps stale slots.
      {r_c, r_d} <= pc1(i_key);
      r_round    <= 5'd1;
      r_busy     <= 1'b1;
      r_vld      <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_round != 5'd0) begin
        r_c <= w_c;
        r_d <= w_d;
        for (int s = 1; s <= ROUNDS; s++) begin
          if (r_round == 5'(s)) begin
            r_keyex[KEYEX_W - SUBKEY_W*s +: SUBKEY_W] <= w_subkey;
          end
        end
        if (r_round == 5'(ROUNDS)) begin
          r_round <= 5'd0;
          r_busy  <= 1'b0;
          r_vld   <= 1'b1;
          r_done  <= 1'b1;
        end else begin
          r_round <= r_round + 5'd1;
        end
      end
    end
  end

  assign o_keyex    = r_keyex;
  assign o_key_vld  = r_vld;
  assign o_key_done = r_done;
  assign o_busy     = r_busy;

endmodule

// File: doc/des_key_sched.md
# des_key_sched

Sequential DES key schedule. It takes one 64-bit key, applies PC-1, and then produces one 48-bit round subkey per clock over 16 cycles. Subkeys are packed into the 768-bit bus that the round-data core consumes as its key-expansion input. The block sits directly upstream of that core. Encrypt/decrypt ordering is the core's job; this block always produces K1..K16 in forward order.

## Interface
Parameters: none. All tables are constants in the shared package.

- i_clk  in  1  sole clock, rising edge. One clock; reset is synchronous and active-high.
- i_rst  in  1  synchronous, active-high reset.
- i_key  in  64  DES key. Bit 1 (FIPS numbering) = i_key[63]. Parity bits 8,16,…,64 are ignored.
- i_key_en  in  1  single-cycle load strobe; i_key is sampled on the same edge.
- o_keyex  out  768  packed subkeys. Kn at [48*(17-n)-1 : 48*(16-n)], so K1 = [767:720] and K16 = [47:0]. Subkey FIPS bit 1 = slice MSB.
- o_key_vld  out  1  level: o_keyex holds a complete schedule.
- o_key_done  out  1  one-cycle pulse when the schedule completes.
- o_busy  out  1  level: schedule generation in progress.

## Operation
- Internal state:
  - r_c, r_d: 28 bits each.
  - r_round: 5 bits, values 0..16; 0 = idle.
  - r_keyex: 768 bits.
  - flags vld, done, busy.
- Load, on an edge with i_key_en=1:
  - {r_c, r_d} <= PC1(i_key), r_c = upper 28 bits.
  - r_round <= 1, busy <= 1, vld <= 0, done <= 0.
  - r_keyex is not cleared.
- Round n (r_round = n, 1..16):
  - Shift: c' = rotl(r_c, s(n)) and d' = rotl(r_d, s(n)), where s = 1 for n ∈ {1, 2, 9, 16} and 2 otherwise.
  - Write PC2({c', d'}) into slot n; r_c <= c', r_d <= d'.
  - n<16: r_round <= n+1.
  - n=16: r_round <= 0, busy <= 0, vld <= 1, done <= 1.
- done is cleared on the next edge, so it is exactly one cycle wide.
- Total rotation over 16 rounds = 28, so C/D return to their PC-1 values; no check is required.
- i_key_en while busy: abort and restart with the new key, same as a load. Slots already written stay stale until overwritten.
- i_key_en while vld=1: vld drops on that edge and a fresh schedule starts.
- vld stays high indefinitely until the next load or reset.
- Downstream must not issue data while o_key_vld=0. o_keyex content is unspecified during busy.

## Timing
- Reset values: o_keyex = 0, o_key_vld = 0, o_key_done = 0, o_busy = 0, r_round = 0, r_c = r_d = 0.
- i_rst has priority over i_key_en. Reset mid-schedule returns to idle with all outputs at reset values.
- Load edge = E0:
  - Kn is registered on edge En, n = 1..16.
  - o_busy is high in the cycles after E0 through E15.
  - o_key_vld and o_key_done rise after E16.
  - Latency from key strobe to valid = 16 cycles.
- Back-to-back strobes on E0 and E1: the schedule restarts from E1; vld rises after E17.
- All outputs come directly from registers. The combinational path is one rotate plus PC-2.

## Structure
- Package des_pkg holds:
  - PC1 index table (56 entries) and PC2 index table (48 entries), both in FIPS 1-based numbering.
  - Shift schedule constant, 16 entries.
  - Localparams for subkey width 48, round count 16, and keyex width 768.
- One sub-module, des_key_round. It is combinational: inputs r_c, r_d, shift amount; outputs c', d', 48-bit subkey. The top module keeps the counter, control flags and the 768-bit store.

## Test plan
- Key 0x133457799BBCDFF1, strobe one cycle -> after 16 cycles:
  - o_key_vld = 1, and o_key_done pulses for exactly one cycle.
  - K1 = 0x1B02EFFC7072, K2 = 0x79AED9DBC9E5, K16 = 0xCB3D8B0E17F5.
- Parity variant 0x123556789ABDDEF0 -> o_keyex identical to the previous case.
- Key 0 -> all 768 bits zero, vld after 16 cycles. Key 0xFFFFFFFFFFFFFFFF -> all 768 bits one.
- Restart while busy:
  - Strobe key A; on the 5th busy cycle strobe 0x133457799BBCDFF1.
  - vld rises 16 cycles after the second strobe, with the first-test values.
  - vld is never high in between.
- Reset mid-schedule: i_rst at round 8 -> next cycle all outputs are at reset values; a following strobe completes normally in 16 cycles.
- Chained check with the round core: schedule the test key, then encrypt 0x0123456789ABCDEF -> ciphertext 0x85E813540F0AB405.
